// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: one IF/ID slot, field/immediate decode, EX issue handshake,
// load-use bubble insertion and branch flush. Optional macro: ILLEGAL_DETECT_EN.
module decode_issue_ctrl #(
  parameter int PC_W       = 32,
  parameter int LU_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_ready,
  input  logic            ex_ready,
  input  logic            ex_flush,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_imm,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic            id_illegal
);

  // state | meaning
  // RUN   | slot may issue; load-use hazard checked against tracked load rd
  // STALL | bubbles owed to EX; bub_cnt counts remaining EX-accepted bubbles

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic {RUN, STALL} state_t;

  state_t      state;
  logic [1:0]  bub_cnt;
  logic        lu_track;
  logic [4:0]  lu_rd;
  logic        slot_valid;
  logic [31:0] imm_next;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        hazard;
  logic        capture;
  logic        transfer;

  always_comb begin
    imm_next = 32'd0;
    case (if_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm_next = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE:  imm_next = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      OP_BRANCH: imm_next = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                             if_instr[30:25], if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm_next = {if_instr[31:12], 12'd0};
      OP_JAL:    imm_next = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                             if_instr[20], if_instr[30:21], 1'b0};
      default:   imm_next = 32'd0;
    endcase
  end

  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];
  assign id_rd  = id_instr[11:7];

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      OP_STORE, OP_BRANCH, OP_REG: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  assign hazard = slot_valid && (state == RUN) && lu_track && (lu_rd != 5'd0) &&
                  ((uses_rs1 && (id_rs1 == lu_rd)) || (uses_rs2 && (id_rs2 == lu_rd)));
  assign id_valid = slot_valid && (state == RUN) && !hazard;
  assign if_ready = !ex_flush && (!slot_valid || (id_valid && ex_ready));
  assign capture  = if_valid && if_ready;
  assign transfer = id_valid && ex_ready && !ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      id_instr   <= 32'd0;
      id_pc      <= '0;
      id_imm     <= 32'd0;
    end else if (ex_flush) begin
      slot_valid <= 1'b0;
    end else if (capture) begin
      slot_valid <= 1'b1;
      id_instr   <= if_instr;
      id_pc      <= if_pc;
      id_imm     <= imm_next;
    end else if (transfer) begin
      slot_valid <= 1'b0;
    end
  end

  // The hazard cycle itself is the first bubble when EX accepts it, so STALL
  // only covers the remaining LU_BUBBLES-1 accepted bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      bub_cnt  <= 2'd0;
      lu_track <= 1'b0;
      lu_rd    <= 5'd0;
    end else if (ex_flush) begin
      state    <= RUN;
      bub_cnt  <= 2'd0;
      lu_track <= 1'b0;
    end else begin
      if (transfer && (id_instr[6:0] == OP_LOAD)) begin
        lu_track <= 1'b1;
        lu_rd    <= id_rd;
      end else if (ex_ready) begin
        lu_track <= 1'b0;
      end
      case (state)
        RUN: begin
          if (hazard && ex_ready && (LU_BUBBLES > 1)) begin
            state   <= STALL;
            bub_cnt <= 2'(LU_BUBBLES - 1);
          end
        end
        STALL: begin
          if (ex_ready) begin
            if (bub_cnt <= 2'd1) begin
              state    <= RUN;
              bub_cnt  <= 2'd0;
              lu_track <= 1'b0;
            end else begin
              bub_cnt <= bub_cnt - 2'd1;
            end
          end
        end
        default: begin
          state   <= RUN;
          bub_cnt <= 2'd0;
        end
      endcase
    end
  end

`ifdef ILLEGAL_DETECT_EN
  logic op_known;

  always_comb begin
    op_known = 1'b0;
    case (id_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_REG: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  assign id_illegal = slot_valid && !op_known;
`else
  assign id_illegal = 1'b0;
`endif

endmodule
